// File: rtl/key_debounce_multi.sv
// Multi-channel push-button conditioner: synchroniser, tick-based debounce and
// a per-channel hold FSM producing press/release/long/repeat single-cycle pulses.
module key_debounce_multi #(
    parameter int KEY_NUM      = 4,
    parameter bit ACTIVE_HIGH  = 1'b1,
    parameter int TICK_CYCLES  = 50000,
    parameter int DEB_TICKS    = 20,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long,
    output logic [KEY_NUM-1:0] key_repeat
);

    localparam int TW = $clog2(TICK_CYCLES);
    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam int RW = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
    localparam logic [KEY_NUM-1:0] IDLE_PIN = {KEY_NUM{~ACTIVE_HIGH}};

    typedef enum logic [1:0] {
        HS_IDLE   = 2'd0,
        HS_HOLD   = 2'd1,
        HS_REPEAT = 2'd2
    } hold_state_e;

    logic [KEY_NUM-1:0] sync1_q, sync2_q, lvl;
    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic               tick;

    // Synchroniser resets to the idle pin level so reset release never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= IDLE_PIN;
            sync2_q <= IDLE_PIN;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    assign lvl  = sync2_q ^ IDLE_PIN;
    assign tick = (tick_cnt_q == TW'(TICK_CYCLES - 1));

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_cnt_q <= '0;
        else        tick_cnt_q <= tick_cnt_d;
    end

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_ch
        logic [DW-1:0] deb_cnt_q, deb_cnt_d;
        logic          st_q, st_d;
        logic          press_ev, rel_ev;
        hold_state_e   hs_q, hs_d;
        logic [HW-1:0] hold_cnt_q, hold_cnt_d;
        logic [RW-1:0] rep_cnt_q, rep_cnt_d;
        logic          press_q, rel_q, long_q, long_d, rep_q, rep_d;

        always_comb begin
            deb_cnt_d = deb_cnt_q;
            st_d      = st_q;
            press_ev  = 1'b0;
            rel_ev    = 1'b0;
            if (lvl[k] == st_q) begin
                deb_cnt_d = '0;
            end else if (tick) begin
                if (deb_cnt_q == DW'(DEB_TICKS - 1)) begin
                    deb_cnt_d = '0;
                    st_d      = ~st_q;
                    press_ev  = ~st_q;
                    rel_ev    = st_q;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
        end

        // Release wins over any long/repeat pulse due on the same tick.
        always_comb begin
            hs_d       = hs_q;
            hold_cnt_d = hold_cnt_q;
            rep_cnt_d  = rep_cnt_q;
            long_d     = 1'b0;
            rep_d      = 1'b0;
            if (rel_ev) begin
                hs_d       = HS_IDLE;
                hold_cnt_d = '0;
                rep_cnt_d  = '0;
            end else begin
                case (hs_q)
                    HS_IDLE: begin
                        if (press_ev) begin
                            hs_d       = HS_HOLD;
                            hold_cnt_d = '0;
                        end
                    end
                    HS_HOLD: begin
                        if (tick && hold_cnt_q != HW'(LONG_TICKS)) begin
                            hold_cnt_d = hold_cnt_q + HW'(1);
                            if (hold_cnt_q == HW'(LONG_TICKS - 1)) begin
                                long_d = 1'b1;
                                if (REPEAT_TICKS > 0) begin
                                    hs_d      = HS_REPEAT;
                                    rep_cnt_d = '0;
                                end
                            end
                        end
                    end
                    HS_REPEAT: begin
                        if (tick) begin
                            if (rep_cnt_q == RW'(REPEAT_TICKS - 1)) begin
                                rep_d     = 1'b1;
                                rep_cnt_d = '0;
                            end else begin
                                rep_cnt_d = rep_cnt_q + RW'(1);
                            end
                        end
                    end
                    default: hs_d = HS_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                deb_cnt_q  <= '0;
                st_q       <= 1'b0;
                hs_q       <= HS_IDLE;
                hold_cnt_q <= '0;
                rep_cnt_q  <= '0;
                press_q    <= 1'b0;
                rel_q      <= 1'b0;
                long_q     <= 1'b0;
                rep_q      <= 1'b0;
            end else begin
                deb_cnt_q  <= deb_cnt_d;
                st_q       <= st_d;
                hs_q       <= hs_d;
                hold_cnt_q <= hold_cnt_d;
                rep_cnt_q  <= rep_cnt_d;
                press_q    <= press_ev;
                rel_q      <= rel_ev;
                long_q     <= long_d;
                rep_q      <= rep_d;
            end
        end

        assign key_state[k]   = st_q;
        assign key_press[k]   = press_q;
        assign key_release[k] = rel_q;
        assign key_long[k]    = long_q;
        assign key_repeat[k]  = rep_q;
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: two instances (active-high with repeat, active-low
// without repeat) share one logical stimulus and are checked against an event model.
`timescale 1ns/1ps
module tb_key_debounce_multi;

    localparam int TC = 4;
    localparam int DB = 3;
    localparam int LG = 10;
    localparam int RP = 4;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  st;
        logic [1:0]  press;
        logic [1:0]  rel;
        logic [1:0]  lng;
        logic [1:0]  rep;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] pr = 2'b00;
    logic [1:0] key_a, key_b;
    logic [1:0] a_st, a_pr, a_rl, a_lg, a_rp;
    logic [1:0] b_st, b_pr, b_rl, b_lg, b_rp;

    int total = 0;
    int bad = 0;
    bit done = 0;
    bit report_done = 0;

    assign key_a = pr;
    assign key_b = ~pr;

    always #5 clk = ~clk;

    key_debounce_multi #(
        .KEY_NUM(2), .ACTIVE_HIGH(1'b1), .TICK_CYCLES(TC),
        .DEB_TICKS(DB), .LONG_TICKS(LG), .REPEAT_TICKS(RP)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .key_in(key_a),
        .key_state(a_st), .key_press(a_pr), .key_release(a_rl),
        .key_long(a_lg), .key_repeat(a_rp)
    );

    key_debounce_multi #(
        .KEY_NUM(2), .ACTIVE_HIGH(1'b0), .TICK_CYCLES(TC),
        .DEB_TICKS(DB), .LONG_TICKS(LG), .REPEAT_TICKS(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .key_in(key_b),
        .key_state(b_st), .key_press(b_pr), .key_release(b_rl),
        .key_long(b_lg), .key_repeat(b_rp)
    );

    // Reference model: pin seen two edges late, debounce by counting
    // differing ticks, long/repeat computed arithmetically from the press edge.
    int         mdl_k;
    logic [1:0] s1[2];
    logic [1:0] s2[2];
    logic [1:0] mst[2];
    int         dcnt[2][2];
    int         ptime[2][2];
    ev_t        exp_q0[$];
    ev_t        exp_q1[$];

    function automatic int q_size(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic ev_t q_front(input int d);
        return (d == 0) ? exp_q0[0] : exp_q1[0];
    endfunction

    task automatic q_pop(input int d);
        if (d == 0) void'(exp_q0.pop_front());
        else        void'(exp_q1.pop_front());
    endtask

    task automatic model_reset();
        mdl_k = 0;
        s1[0] = 2'b00; s2[0] = 2'b00;
        s1[1] = 2'b11; s2[1] = 2'b11;
        for (int d = 0; d < 2; d++) begin
            mst[d] = 2'b00;
            for (int c = 0; c < 2; c++) begin
                dcnt[d][c]  = 0;
                ptime[d][c] = 0;
            end
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic model_step(input int d, input logic [1:0] pins, input bit ah,
                              input int rp, output ev_t ev, output bit any);
        bit tick;
        bit lv;
        int dt;
        tick   = (mdl_k % TC) == TC - 1;
        ev     = '0;
        ev.cyc = 32'(mdl_k);
        for (int c = 0; c < 2; c++) begin
            lv = ah ? s2[d][c] : ~s2[d][c];
            if (lv == mst[d][c]) begin
                dcnt[d][c] = 0;
            end else if (tick) begin
                dcnt[d][c]++;
                if (dcnt[d][c] == DB) begin
                    dcnt[d][c] = 0;
                    mst[d][c]  = lv;
                    if (lv) begin
                        ev.press[c] = 1'b1;
                        ptime[d][c] = mdl_k;
                    end else begin
                        ev.rel[c] = 1'b1;
                    end
                end
            end
            if (tick && mst[d][c] && !ev.press[c]) begin
                dt = (mdl_k - ptime[d][c]) / TC;
                if (dt == LG) ev.lng[c] = 1'b1;
                else if (rp > 0 && dt > LG && (dt - LG) % rp == 0) ev.rep[c] = 1'b1;
            end
        end
        s2[d] = s1[d];
        s1[d] = pins;
        ev.st = mst[d];
        any = |{ev.press, ev.rel, ev.lng, ev.rep};
    endtask

    initial begin
        ev_t ev;
        bit  any;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                model_step(0, key_a, 1'b1, RP, ev, any);
                if (any) exp_q0.push_back(ev);
                model_step(1, key_b, 1'b0, 0, ev, any);
                if (any) exp_q1.push_back(ev);
                mdl_k++;
            end
        end
    end

    task automatic check_dut(input int d, input logic [1:0] st, input logic [1:0] p,
                             input logic [1:0] r, input logic [1:0] l, input logic [1:0] rp);
        int  cur;
        ev_t e;
        cur = mdl_k - 1;
        total++;
        if (st !== mst[d]) begin
            bad++;
            $display("FAIL state dut%0d cyc=%0d got=%b exp=%b", d, cur, st, mst[d]);
        end
        while (q_size(d) > 0) begin
            e = q_front(d);
            if (e.cyc >= 32'(cur)) break;
            total++;
            bad++;
            $display("FAIL missed dut%0d cyc=%0d got=none exp=press%b rel%b long%b rep%b",
                     d, e.cyc, e.press, e.rel, e.lng, e.rep);
            q_pop(d);
        end
        if (|{p, r, l, rp}) begin
            total++;
            e = '0;
            if (q_size(d) > 0) e = q_front(d);
            if (q_size(d) == 0 || e.cyc != 32'(cur)) begin
                bad++;
                $display("FAIL unexpected dut%0d cyc=%0d got=press%b rel%b long%b rep%b exp=none",
                         d, cur, p, r, l, rp);
            end else begin
                q_pop(d);
                if ({p, r, l, rp, st} !== {e.press, e.rel, e.lng, e.rep, e.st}) begin
                    bad++;
                    $display("FAIL pulses dut%0d cyc=%0d got=%b_%b_%b_%b_%b exp=%b_%b_%b_%b_%b",
                             d, cur, p, r, l, rp, st, e.press, e.rel, e.lng, e.rep, e.st);
                end
            end
        end
    endtask

    // Monitor: pops the expected queue whenever a DUT shows a pulse.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                total++;
                if ({a_st, a_pr, a_rl, a_lg, a_rp} !== 10'd0) begin
                    bad++;
                    $display("FAIL reset_a got=%b exp=0", {a_st, a_pr, a_rl, a_lg, a_rp});
                end
                total++;
                if ({b_st, b_pr, b_rl, b_lg, b_rp} !== 10'd0) begin
                    bad++;
                    $display("FAIL reset_b got=%b exp=0", {b_st, b_pr, b_rl, b_lg, b_rp});
                end
            end else if (mdl_k > 0) begin
                check_dut(0, a_st, a_pr, a_rl, a_lg, a_rp);
                check_dut(1, b_st, b_pr, b_rl, b_lg, b_rp);
            end
            if (done && !report_done) begin
                for (int d = 0; d < 2; d++) begin
                    while (q_size(d) > 0) begin
                        e = q_front(d);
                        total++;
                        bad++;
                        $display("FAIL leftover dut%0d cyc=%0d got=none exp=press%b rel%b long%b rep%b",
                                 d, e.cyc, e.press, e.rel, e.lng, e.rep);
                        q_pop(d);
                    end
                end
                report_done = 1;
            end
        end
    end

    task automatic drive(input logic [1:0] v, input int n);
        pr = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        pr = 2'b00;
        pulse_reset();
        drive(2'b00, 30);
        drive(2'b01, 30);
        drive(2'b00, 30);
        for (int i = 0; i < 8; i++) drive({pr[1], ~pr[0]}, 5);
        drive(2'b01, 30);
        drive(2'b00, 30);
        drive(2'b10, 200);
        drive(2'b00, 40);
        drive(2'b11, 30);
        drive(2'b00, 30);
        drive(2'b01, 80);
        pulse_reset();
        drive(2'b01, 40);
        drive(2'b00, 30);
        for (int i = 0; i < 40; i++) drive(2'($urandom_range(0, 3)), int'($urandom_range(1, 60)));
        drive(2'b00, 40);
        done = 1;
        for (int i = 0; i < 20 && !report_done; i++) @(posedge clk);
        if (!report_done) begin
            $display("FAIL report_timeout got=pending exp=done");
            $fatal(1, "monitor did not complete");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
